vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised video timing generator producing sync, data-enable, coordinates and frame-event pulses for any progressive VGA-class mode. It is the next generation of the fixed 800x600 driver. Porch/sync widths, sync polarity and counter width are parameters, and all outputs are registered. It adds a start-of-line pulse, a start-of-frame pulse and a frame counter. It sits between the pixel-strobe generator and the framebuffer/sprite pipeline.

Parameters:
H_ACTIVE, 800, active pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, active lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
H_POL, 1, hsync active level (1 = active high)
V_POL, 1, vsync active level
CORDW, 11, coordinate width; must hold max(H_TOTAL,V_TOTAL)-1
FRAMEW, 16, frame counter width

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_pix_stb  input  1  pixel strobe; one pixel advance per high cycle
o_hs  output  1  horizontal sync, level per H_POL
o_vs  output  1  vertical sync, level per V_POL
o_de  output  1  high while the position is in the active area
o_x  output  CORDW  raw horizontal count, 0..H_TOTAL-1
o_y  output  CORDW  raw vertical count, 0..V_TOTAL-1
o_line  output  1  one-clock pulse at the start of each line
o_frame  output  1  one-clock pulse at the start of each frame
o_animate  output  1  one-clock pulse at the end of the last active line
o_frame_count  output  FRAMEW  completed-frame counter

Behaviour:
- Derived values: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- Line order: active region first, then front porch, sync and back porch. Active area is h<H_ACTIVE and v<V_ACTIVE.
- Counters advance only on i_clk edges where i_pix_stb=1.
  - h: h==H_TOTAL-1 wraps to 0; otherwise h increments.
  - v: increments only when h wraps. v==V_TOTAL-1 with h wrapping sends v to 0.
- o_x/o_y equal the counters directly; they are not clamped.
- o_hs, o_vs and o_de are registered and are always consistent with o_x/o_y in the same cycle. Implement them by decoding the next-count values.
  - o_hs=H_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
  - o_vs=V_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; otherwise ~V_POL.
  - o_de = (h<H_ACTIVE)&(v<V_ACTIVE).
- Pulses are high for exactly one i_clk cycle: the cycle after the strobe edge that moves the counters into the event position. Between strobes they are 0, even when the strobe is infrequent.
  - o_line: new h==0.
  - o_frame: new h==0 and v==0.
  - o_animate: new h==H_TOTAL-1 and v==V_ACTIVE-1.
- o_frame_count increments by 1 on the same edge that raises o_frame and wraps modulo 2^FRAMEW.
- Reset has priority over i_pix_stb, including mid-line or mid-frame. On reset:
  - h=H_TOTAL-1, v=V_TOTAL-1, o_x=H_TOTAL-1, o_y=V_TOTAL-1.
  - o_de=0, o_hs=~H_POL, o_vs=~V_POL.
  - o_line=o_frame=o_animate=0, o_frame_count=0.
- The first strobe after reset moves to (0,0) and raises o_line, o_frame and o_de. o_frame_count becomes 1 on that strobe.
- i_pix_stb tied high is legal: one pixel per clock, pulses still last one clock.
- With i_pix_stb=0 all outputs hold, and the pulses drop to 0.

Test Plan:
- Reset, then i_pix_stb=1 continuous, default params -> first cycle after strobe: o_x=0, o_y=0, o_de=1, o_line=o_frame=1, o_frame_count=1. o_de falls at o_x=800.
- Horizontal sync -> o_hs=1 exactly for o_x=840..967 (128 clocks) on every line. o_x wraps 1055->0 with o_y incrementing and o_line pulsing.
- Full frame -> o_vs=1 for o_y=601..604. o_animate pulses once at (1055,599). Next o_frame occurs 1056*628=663168 strobes after the previous one, and o_frame_count becomes 2.
- Params H_POL=0, V_POL=0 with a small mode (H 8/2/2/2, V 4/1/1/1) -> o_hs low only at x=10..11, o_vs low only at y=5. H_TOTAL=14, V_TOTAL=7 wrap checked.
- i_pix_stb every 4th clock -> counters advance once per 4 clocks, and each pulse lasts one clock, not four.
- Assert i_rst at (400,300) together with i_pix_stb=1 -> next cycle shows reset values (x=1055, y=627, de=0, frame_count=0). The following strobe gives (0,0) with an o_frame pulse. FRAMEW=2 over 5 frames -> count 1,2,3,0,1.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised progressive video timing generator. Produces
//             horizontal/vertical sync, data enable, raw beam coordinates,
//             start-of-line / start-of-frame / end-of-active pulses and a
//             completed-frame counter. The beam advances one pixel on every
//             i_clk edge where i_pix_stb is high.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk          system clock
//    i_rst          synchronous active-high reset (priority over i_pix_stb)
//    i_pix_stb      pixel strobe, one pixel advance per high cycle
//    o_hs           horizontal sync, active level H_POL
//    o_vs           vertical sync, active level V_POL
//    o_de           high while the beam is inside the active area
//    o_x            raw horizontal count, 0..H_TOTAL-1
//    o_y            raw vertical count, 0..V_TOTAL-1
//    o_line         one-clock pulse when a new line starts (x becomes 0)
//    o_frame        one-clock pulse when a new frame starts (x,y become 0,0)
//    o_animate      one-clock pulse at the last pixel of the last active line
//    o_frame_count  number of frames started since reset, modulo 2^FRAMEW
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int CORDW    = 11,
  parameter int FRAMEW   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_stb,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_de,
  output logic [CORDW-1:0]  o_x,
  output logic [CORDW-1:0]  o_y,
  output logic              o_line,
  output logic              o_frame,
  output logic              o_animate,
  output logic [FRAMEW-1:0] o_frame_count
);

  // --------------------------------------------------------------------------
  // Derived timing constants. Each line/frame is ordered
  // active -> front porch -> sync -> back porch.
  // --------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] c_h_last     = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] c_v_last     = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] c_h_act      = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] c_v_act      = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] c_v_act_last = CORDW'(V_ACTIVE - 1);
  localparam logic [CORDW-1:0] c_hs_start   = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] c_hs_end     = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] c_vs_start   = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] c_vs_end     = CORDW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] c_cord_zero  = '0;
  localparam logic [CORDW-1:0] c_cord_one   = {{(CORDW-1){1'b0}}, 1'b1};
  localparam logic [FRAMEW-1:0] c_frame_one = {{(FRAMEW-1){1'b0}}, 1'b1};

  // Active sync levels reduced to single bits.
  localparam logic c_hs_on = (H_POL != 0);
  localparam logic c_vs_on = (V_POL != 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CORDW-1:0]  h_q, h_d;
  logic [CORDW-1:0]  v_q, v_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              de_q, de_d;
  logic              line_q, line_d;
  logic              frame_q, frame_d;
  logic              anim_q, anim_d;
  logic [FRAMEW-1:0] fc_q, fc_d;

  // --------------------------------------------------------------------------
  // Next beam position. The vertical counter only moves when the horizontal
  // counter wraps.
  // --------------------------------------------------------------------------
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (i_pix_stb) begin
      if (h_q == c_h_last) begin
        h_d = c_cord_zero;
        if (v_q == c_v_last) begin
          v_d = c_cord_zero;
        end else begin
          v_d = v_q + c_cord_one;
        end
      end else begin
        h_d = h_q + c_cord_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output decode. Sync and enable are decoded from the next position so that
  // once registered they line up with o_x/o_y in the same cycle. Without a
  // strobe the next position equals the current one, so these levels hold.
  // The event pulses are gated by the strobe so they last exactly one clock
  // even when the strobe is sparse.
  // --------------------------------------------------------------------------
  always_comb begin
    hs_d    = ((h_d >= c_hs_start) && (h_d < c_hs_end)) ? c_hs_on : ~c_hs_on;
    vs_d    = ((v_d >= c_vs_start) && (v_d < c_vs_end)) ? c_vs_on : ~c_vs_on;
    de_d    = (h_d < c_h_act) && (v_d < c_v_act);
    line_d  = i_pix_stb && (h_d == c_cord_zero);
    frame_d = i_pix_stb && (h_d == c_cord_zero) && (v_d == c_cord_zero);
    anim_d  = i_pix_stb && (h_d == c_h_last) && (v_d == c_v_act_last);
    fc_d    = frame_d ? (fc_q + c_frame_one) : fc_q;
  end

  // --------------------------------------------------------------------------
  // Registers. Reset parks the beam on the last pixel of the last line so the
  // first strobe lands on (0,0) and produces a start-of-frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q     <= c_h_last;
      v_q     <= c_v_last;
      hs_q    <= ~c_hs_on;
      vs_q    <= ~c_vs_on;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      anim_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      anim_q  <= anim_d;
      fc_q    <= fc_d;
    end
  end

  assign o_x           = h_q;
  assign o_y           = v_q;
  assign o_hs          = hs_q;
  assign o_vs          = vs_q;
  assign o_de          = de_q;
  assign o_line        = line_q;
  assign o_frame       = frame_q;
  assign o_animate     = anim_q;
  assign o_frame_count = fc_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. Two instances run side
//             by side: A uses the default 800x600 mode, B a tiny mode with
//             active-low syncs and a 2-bit frame counter. A behavioural beam
//             model per instance pushes expected outputs into a queue as each
//             cycle's stimulus is driven; they are popped and compared after
//             the clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit de;
    bit line;
    bit frame;
    bit anim;
    int fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        stb_a = 1'b0, rst_a = 1'b0, stb_b = 1'b0, rst_b = 1'b0;
  logic        hs_a, vs_a, de_a, line_a, frame_a, anim_a;
  logic [10:0] x_a, y_a;
  logic [15:0] fc_a;
  logic        hs_b, vs_b, de_b, line_b, frame_b, anim_b;
  logic [3:0]  x_b, y_b;
  logic [1:0]  fc_b;

  int n_checks = 0;
  int n_errors = 0;

  // Mode tables for the model: index 0 = instance A, 1 = instance B.
  int P_HA[2] = '{800, 8};
  int P_HF[2] = '{40, 2};
  int P_HS[2] = '{128, 2};
  int P_HB[2] = '{88, 2};
  int P_VA[2] = '{600, 4};
  int P_VF[2] = '{1, 1};
  int P_VS[2] = '{4, 1};
  int P_VB[2] = '{23, 1};
  int P_HP[2] = '{1, 0};
  int P_VP[2] = '{1, 0};
  int P_FW[2] = '{16, 2};

  int   mh[2];
  int   mv[2];
  int   mfc[2];
  exp_t eo[2];
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_pix_stb(stb_a),
    .o_hs(hs_a), .o_vs(vs_a), .o_de(de_a), .o_x(x_a), .o_y(y_a),
    .o_line(line_a), .o_frame(frame_a), .o_animate(anim_a),
    .o_frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(0), .V_POL(0), .CORDW(4), .FRAMEW(2)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_pix_stb(stb_b),
    .o_hs(hs_b), .o_vs(vs_b), .o_de(de_b), .o_x(x_b), .o_y(y_b),
    .o_line(line_b), .o_frame(frame_b), .o_animate(anim_b),
    .o_frame_count(fc_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Behavioural beam model: one call per clock, with that cycle's inputs.
  task automatic model(input int s, input bit stb, input bit rst, output exp_t e);
    int ht, vt, hs0, vs0;
    ht  = P_HA[s] + P_HF[s] + P_HS[s] + P_HB[s];
    vt  = P_VA[s] + P_VF[s] + P_VS[s] + P_VB[s];
    hs0 = P_HA[s] + P_HF[s];
    vs0 = P_VA[s] + P_VF[s];
    if (rst) begin
      mh[s] = ht - 1;
      mv[s] = vt - 1;
      mfc[s] = 0;
      eo[s].hs = (P_HP[s] == 0);
      eo[s].vs = (P_VP[s] == 0);
      eo[s].de = 1'b0;
      eo[s].line = 1'b0;
      eo[s].frame = 1'b0;
      eo[s].anim = 1'b0;
    end else if (stb) begin
      mh[s] = mh[s] + 1;
      if (mh[s] == ht) begin
        mh[s] = 0;
        mv[s] = mv[s] + 1;
        if (mv[s] == vt) mv[s] = 0;
      end
      eo[s].de    = (mh[s] < P_HA[s]) && (mv[s] < P_VA[s]);
      eo[s].hs    = (mh[s] >= hs0 && mh[s] < hs0 + P_HS[s]) ? (P_HP[s] != 0) : (P_HP[s] == 0);
      eo[s].vs    = (mv[s] >= vs0 && mv[s] < vs0 + P_VS[s]) ? (P_VP[s] != 0) : (P_VP[s] == 0);
      eo[s].line  = (mh[s] == 0);
      eo[s].frame = (mh[s] == 0) && (mv[s] == 0);
      eo[s].anim  = (mh[s] == ht - 1) && (mv[s] == P_VA[s] - 1);
      if (eo[s].frame) mfc[s] = (mfc[s] + 1) % (1 << P_FW[s]);
    end else begin
      eo[s].line = 1'b0;
      eo[s].frame = 1'b0;
      eo[s].anim = 1'b0;
    end
    eo[s].x  = mh[s];
    eo[s].y  = mv[s];
    eo[s].fc = mfc[s];
    e = eo[s];
  endtask

  task automatic cmp_a(input exp_t e);
    check("A.x", 32'(x_a), e.x);
    check("A.y", 32'(y_a), e.y);
    check("A.hs", 32'(hs_a), 32'(e.hs));
    check("A.vs", 32'(vs_a), 32'(e.vs));
    check("A.de", 32'(de_a), 32'(e.de));
    check("A.line", 32'(line_a), 32'(e.line));
    check("A.frame", 32'(frame_a), 32'(e.frame));
    check("A.animate", 32'(anim_a), 32'(e.anim));
    check("A.frame_count", 32'(fc_a), e.fc);
  endtask

  task automatic cmp_b(input exp_t e);
    check("B.x", 32'(x_b), e.x);
    check("B.y", 32'(y_b), e.y);
    check("B.hs", 32'(hs_b), 32'(e.hs));
    check("B.vs", 32'(vs_b), 32'(e.vs));
    check("B.de", 32'(de_b), 32'(e.de));
    check("B.line", 32'(line_b), 32'(e.line));
    check("B.frame", 32'(frame_b), 32'(e.frame));
    check("B.animate", 32'(anim_b), 32'(e.anim));
    check("B.frame_count", 32'(fc_b), e.fc);
  endtask

  // One clock: drive inputs, queue the model's prediction, let the edge pass,
  // then compare what the DUTs show against the queued prediction.
  task automatic cyc(input bit sa, input bit ra, input bit sb, input bit rb);
    exp_t ea, eb;
    stb_a = sa; rst_a = ra; stb_b = sb; rst_b = rb;
    model(0, sa, ra, ea);
    qa.push_back(ea);
    model(1, sb, rb, eb);
    qb.push_back(eb);
    @(posedge clk);
    #1;
    cmp_a(qa.pop_front());
    cmp_b(qb.pop_front());
  endtask

  initial begin
    int hcnt, hmin, hmax, defall, lines, frames, anims;
    int vlow, vbad, hlow, hbad, xmax, ymax, nf;
    int fcs[8];

    // Reset both instances for a few cycles.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("A.rst_x", 32'(x_a), 1055);
    check("A.rst_y", 32'(y_a), 627);

    // ---- Instance A: continuous strobe over two full lines and a bit ----
    hcnt = 0; hmin = 9999; hmax = -1; defall = -1; lines = 0;
    for (int i = 0; i < 2 * 1056 + 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        check("A.first_x", 32'(x_a), 0);
        check("A.first_y", 32'(y_a), 0);
        check("A.first_de", 32'(de_a), 1);
        check("A.first_frame", 32'(frame_a), 1);
        check("A.first_fc", 32'(fc_a), 1);
      end
      if (y_a == 11'd0 && hs_a) begin
        hcnt++;
        if (int'(x_a) < hmin) hmin = int'(x_a);
        if (int'(x_a) > hmax) hmax = int'(x_a);
      end
      if (y_a == 11'd0 && !de_a && defall < 0) defall = int'(x_a);
      if (line_a) lines++;
    end
    check("A.hs_count", hcnt, 128);
    check("A.hs_first_x", hmin, 840);
    check("A.hs_last_x", hmax, 967);
    check("A.de_fall_x", defall, 800);
    check("A.line_pulses", lines, 3);
    check("A.line2_y", 32'(y_a), 2);

    // Run to x=400 and reset there with the strobe also high.
    for (int i = 0; i < 396; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("A.pre_rst_x", 32'(x_a), 400);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("A.midrst_x", 32'(x_a), 1055);
    check("A.midrst_y", 32'(y_a), 627);
    check("A.midrst_de", 32'(de_a), 0);
    check("A.midrst_fc", 32'(fc_a), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("A.post_rst_frame", 32'(frame_a), 1);
    check("A.post_rst_x", 32'(x_a), 0);

    // ---- Instance B: strobe every 4th clock for two frames ----
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    lines = 0; frames = 0; anims = 0; vlow = 0; vbad = 0; hlow = 0; hbad = 0;
    xmax = 0; ymax = 0;
    for (int i = 0; i < 98 * 2 * 4; i++) begin
      cyc(1'b0, 1'b0, (i % 4) == 0, 1'b0);
      if (line_b) lines++;
      if (frame_b) frames++;
      if (anim_b) anims++;
      if (!vs_b) begin
        vlow++;
        if (y_b != 4'd5) vbad++;
      end
      if (!hs_b) begin
        hlow++;
        if (x_b != 4'd10 && x_b != 4'd11) hbad++;
      end
      if (int'(x_b) > xmax) xmax = int'(x_b);
      if (int'(y_b) > ymax) ymax = int'(y_b);
    end
    check("B.line_pulse_clocks", lines, 14);
    check("B.frame_pulse_clocks", frames, 2);
    check("B.animate_pulse_clocks", anims, 2);
    check("B.vs_low_clocks", vlow, 112);
    check("B.vs_low_outside_y5", vbad, 0);
    check("B.hs_low_clocks", hlow, 112);
    check("B.hs_low_outside_x10_11", hbad, 0);
    check("B.x_max", xmax, 13);
    check("B.y_max", ymax, 6);

    // ---- Instance B: continuous strobe, frame counter wrap over 5 frames ----
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    nf = 0;
    for (int i = 0; i < 98 * 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      if (frame_b && nf < 8) begin
        fcs[nf] = int'(fc_b);
        nf++;
      end
    end
    check("B.frames_seen", nf, 5);
    check("B.fc_frame1", fcs[0], 1);
    check("B.fc_frame2", fcs[1], 2);
    check("B.fc_frame3", fcs[2], 3);
    check("B.fc_frame4", fcs[3], 0);
    check("B.fc_frame5", fcs[4], 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
